// File: rtl/intr_pkg.sv
// Shared constants for the interrupt sequencer: FSM state codes, vector addresses, CCR bit positions.
package intr_pkg;

    localparam logic [7:0] RESET_VEC_ADDR = 8'h00;
    localparam logic [7:0] VEC_ADDR       = 8'h01;

    // CCR is packed {V,C,N,Z}
    localparam int CCR_Z = 0;
    localparam int CCR_N = 1;
    localparam int CCR_C = 2;
    localparam int CCR_V = 3;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_SAVE = 3'd1;
    localparam logic [2:0] ST_VEC  = 3'd2;
    localparam logic [2:0] ST_JUMP = 3'd3;
    localparam logic [2:0] ST_ISR  = 3'd4;

    // Fetch must be frozen while context is being saved and the vector fetched.
    function automatic logic busy_state(input logic [2:0] s);
        return (s == ST_SAVE) || (s == ST_VEC) || (s == ST_JUMP);
    endfunction

endpackage

// File: rtl/intr_ctrl_if.sv
// Bundle between the interrupt sequencer (slave side) and the processor fetch/stack logic (master side).
interface intr_ctrl_if #(parameter int DATA_W = 8);

    logic              int_async;
    logic              boundary_ok;
    logic [DATA_W-1:0] fetch_pc;
    logic [3:0]        ccr_in;
    logic              rti_retire;
    logic              save_req;
    logic [DATA_W-1:0] save_pc;
    logic [3:0]        save_ccr;
    logic              save_ack;
    logic              vec_req;
    logic [DATA_W-1:0] vec_addr;
    logic [DATA_W-1:0] vec_data;
    logic              vec_ack;
    logic              pc_load;
    logic [DATA_W-1:0] pc_load_val;
    logic              stall_fetch;
    logic              flush;
    logic              in_service;

    modport slave (
        input  int_async, boundary_ok, fetch_pc, ccr_in, rti_retire,
               save_ack, vec_data, vec_ack,
        output save_req, save_pc, save_ccr, vec_req, vec_addr,
               pc_load, pc_load_val, stall_fetch, flush, in_service
    );

    modport master (
        output int_async, boundary_ok, fetch_pc, ccr_in, rti_retire,
               save_ack, vec_data, vec_ack,
        input  save_req, save_pc, save_ccr, vec_req, vec_addr,
               pc_load, pc_load_val, stall_fetch, flush, in_service
    );

endinterface

// File: rtl/intr_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin followed by a single-cycle rising-edge pulse.
module intr_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic [STAGES-1:0] sync_q, sync_d;
    logic              last_q, last_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], async_in};
        last_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            last_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            last_q <= last_d;
        end
    end

    // A held-high level yields one pulse because last_q catches up a cycle later.
    assign rise = sync_q[STAGES-1] & ~last_q;

endmodule

// File: rtl/intr_ctrl.sv
// Interrupt sequencer: sync/edge-detect, save PC/CCR, fetch ISR vector, load PC, mask until RTI.
// Optional macro INTC_PEND_IN_ISR_EN keeps edges seen outside IDLE pending for the next sequence.
module intr_ctrl #(
    parameter int                DATA_W      = 8,
    parameter logic [DATA_W-1:0] VEC_ADDR    = DATA_W'(intr_pkg::VEC_ADDR),
    parameter int                SYNC_STAGES = 2
) (
    input logic        clk,
    input logic        rst,
    intr_ctrl_if.slave bus
);

    import intr_pkg::*;

    logic              int_rise;
    logic [2:0]        state_q, state_d;
    logic              pending_q, pending_d;
    logic              flush_q, flush_d;
    logic [DATA_W-1:0] save_pc_q, save_pc_d;
    logic [3:0]        save_ccr_q, save_ccr_d;
    logic [DATA_W-1:0] vec_q, vec_d;

    intr_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (bus.int_async),
        .rise     (int_rise)
    );

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        flush_d    = 1'b0;
        save_pc_d  = save_pc_q;
        save_ccr_d = save_ccr_q;
        vec_d      = vec_q;
        case (state_q)
            ST_IDLE: begin
                if (pending_q && bus.boundary_ok) begin
                    state_d    = ST_SAVE;
                    pending_d  = 1'b0;
                    flush_d    = 1'b1;
                    save_pc_d  = bus.fetch_pc;
                    save_ccr_d = bus.ccr_in;
                end else begin
                    pending_d = pending_q | int_rise;
                end
            end
            ST_SAVE: if (bus.save_ack) state_d = ST_VEC;
            ST_VEC: begin
                if (bus.vec_ack) begin
                    vec_d   = bus.vec_data;
                    state_d = ST_JUMP;
                end
            end
            ST_JUMP: state_d = ST_ISR;
            ST_ISR:  if (bus.rti_retire) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (state_q != ST_IDLE) begin
`ifdef INTC_PEND_IN_ISR_EN
            pending_d = pending_q | int_rise;
`else
            pending_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pending_q  <= 1'b0;
            flush_q    <= 1'b0;
            save_pc_q  <= '0;
            save_ccr_q <= '0;
            vec_q      <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            flush_q    <= flush_d;
            save_pc_q  <= save_pc_d;
            save_ccr_q <= save_ccr_d;
            vec_q      <= vec_d;
        end
    end

    assign bus.save_req    = (state_q == ST_SAVE);
    assign bus.save_pc     = save_pc_q;
    assign bus.save_ccr    = save_ccr_q;
    assign bus.vec_req     = (state_q == ST_VEC);
    assign bus.vec_addr    = VEC_ADDR;
    assign bus.pc_load     = (state_q == ST_JUMP);
    assign bus.pc_load_val = (state_q == ST_JUMP) ? vec_q : '0;
    assign bus.stall_fetch = busy_state(state_q);
    assign bus.flush       = flush_q;
    assign bus.in_service  = (state_q == ST_ISR);

endmodule
